uart_tx_arbiter: RTL and testbench

Shares the single USB-UART TX pin between two byte-stream requesters and serializes the selected stream as 8N1. Requester 0 is the core UART; requester 1 is a debug/boot-monitor stream. The block sits between the core and the board TX pin, in the PLL clock domain. Grant is held per line, so text lines from the two sources never interleave mid-line.

---
 rtl/uart_tx_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART TX pin between two byte-stream requesters and serializes
//   the selected stream as 8N1 (8E1 when UART_ARB_PARITY_EN is defined).
//   Requester 0 is the core UART, requester 1 the debug/boot-monitor stream.
//   Grant is held per line: it is released only after the owner's EOL byte is
//   accepted, or after the owner has been idle for HOLD_TIMEOUT cycles, so
//   text lines from the two sources never interleave.
//
// Optional feature macro: UART_ARB_PARITY_EN
//   Inserts an even-parity bit between the data bits and the stop bit.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous reset, active-high
//   req0_valid/_data    requester 0 byte offer
//   req0_ready          requester 0 byte accepted this cycle (combinational)
//   req1_valid/_data    requester 1 byte offer
//   req1_ready          requester 1 byte accepted this cycle (combinational)
//   tx                  serial output, idle high
//   busy                a frame is in progress
//   grant               one-hot current owner, 2'b00 = none
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int         BAUD_DIV     = 868,
  parameter int         HOLD_TIMEOUT = 4096,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic [1:0] grant
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int TO_W  = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(HOLD_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(HOLD_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_ARB_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [TO_W-1:0]  r_idle_cnt;
  logic [1:0]       r_grant;
  logic             r_last_owner;   // 0 = req0 owned last, 1 = req1
`ifdef UART_ARB_PARITY_EN
  logic             r_parity;
`endif

  logic       w_idle;
  logic       w_baud_done;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_accept;
  logic [7:0] w_acc_data;
  logic       w_owner_valid;
  logic       w_owner_idle;
  logic       w_timeout;
  logic       w_eol;

  assign w_idle      = (r_state == S_IDLE);
  assign w_baud_done = !w_idle && (r_baud_cnt == BAUD_LAST);

  // Grant is one-hot, so at most one ready can be high, and never mid-frame.
  assign w_rdy0     = w_idle & r_grant[0] & req0_valid;
  assign w_rdy1     = w_idle & r_grant[1] & req1_valid;
  assign w_accept   = w_rdy0 | w_rdy1;
  assign w_acc_data = r_grant[1] ? req1_data : req0_data;
  assign w_eol      = w_accept && (w_acc_data == EOL_CHAR);

  // Only the owner's valid feeds the hold timer; the other requester is ignored.
  assign w_owner_valid = (r_grant[0] & req0_valid) | (r_grant[1] & req1_valid);
  assign w_owner_idle  = w_idle & (|r_grant) & ~w_owner_valid;
  assign w_timeout     = w_owner_idle && (r_idle_cnt == TO_LAST);

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign grant      = r_grant;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_state_next = S_START;
      S_START: if (w_baud_done) w_state_next = S_DATA;
      S_DATA: begin
        if (w_baud_done && (r_bit_idx == 3'd7)) begin
`ifdef UART_ARB_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef UART_ARB_PARITY_EN
      S_PARITY: if (w_baud_done) w_state_next = S_STOP;
`endif
      S_STOP:  if (w_baud_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: tx derives from state only, so an async reset forces it high
  // immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (r_state)
      S_IDLE:   busy = 1'b0;
      S_START:  tx   = 1'b0;
      S_DATA:   tx   = r_shift[0];
`ifdef UART_ARB_PARITY_EN
      S_PARITY: tx   = r_parity;
`endif
      S_STOP:   tx   = 1'b1;
      default: begin
        tx   = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit timing and shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
`ifdef UART_ARB_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if (w_idle || w_baud_done) r_baud_cnt <= '0;
      else                       r_baud_cnt <= r_baud_cnt + CNT_W'(1);

      if (w_accept) begin
        r_shift   <= w_acc_data;
        r_bit_idx <= '0;
`ifdef UART_ARB_PARITY_EN
        r_parity  <= ^w_acc_data;
`endif
      end else if ((r_state == S_DATA) && w_baud_done) begin
        // LSB first; the index wraps to 0 after the eighth bit.
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration, grant hold and release
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= 2'b00;
      r_last_owner <= 1'b1;   // req0 wins the first contest
      r_idle_cnt   <= '0;
    end else if (r_grant == 2'b00) begin
      r_idle_cnt <= '0;
      // Round robin: on contention the requester that did not own last wins.
      if (req0_valid && (!req1_valid || r_last_owner)) r_grant <= 2'b01;
      else if (req1_valid)                             r_grant <= 2'b10;
    end else if (w_eol || w_timeout) begin
      r_grant      <= 2'b00;
      r_last_owner <= r_grant[1];
      r_idle_cnt   <= '0;
    end else if (w_owner_idle) begin
      if (r_idle_cnt != TO_MAX) r_idle_cnt <= r_idle_cnt + TO_W'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed scenarios followed by a randomized phase. A behavioural model
//   tracks the owner, the hold timer and the frame as an array of bit values
//   indexed by elapsed time; every cycle the DUT outputs are compared with it.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int         BAUD_DIV     = 4;
  localparam int         HOLD_TIMEOUT = 8;
  localparam logic [7:0] EOL_CHAR     = 8'h0A;
`ifdef UART_ARB_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * BAUD_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx, busy;
  logic [1:0] grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .BAUD_DIV     (BAUD_DIV),
    .HOLD_TIMEOUT (HOLD_TIMEOUT),
    .EOL_CHAR     (EOL_CHAR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx         (tx),
    .busy       (busy),
    .grant      (grant)
  );

  int vectors, miscompares, cyc;

  // Reference model state
  int   m_owner;     // -1 none, 0 or 1
  int   m_last;      // last owner
  int   m_low;       // consecutive idle cycles with owner valid low
  int   m_t;         // cycles into current frame, -1 when idle
  bit   m_bits[NB];
  bit   e_tx, e_busy, e_rdy0, e_rdy1;
  logic [1:0] e_grant;

  // Stimulus and observation
  logic [7:0] q0[$], q1[$];
  bit         rand_mode;
  int         busy_cnt;
  bit         txs[$];
  int         acc_log[$];
  bit         track;
  int         t_idle, t_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_ARB_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 7) == 0) return EOL_CHAR;
    return 8'($urandom);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_low   = 0;
    m_t     = -1;
  endtask

  task automatic model_outputs();
    e_busy  = (m_t >= 0);
    e_tx    = e_busy ? m_bits[m_t / BAUD_DIV] : 1'b1;
    e_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    e_rdy0  = !e_busy && (m_owner == 0) && req0_valid;
    e_rdy1  = !e_busy && (m_owner == 1) && req1_valid;
  endtask

  task automatic model_edge();
    bit         acc, ov;
    logic [7:0] ad;
    acc = e_rdy0 || e_rdy1;
    ad  = e_rdy0 ? req0_data : req1_data;
    ov  = (m_owner == 0) ? req0_valid : req1_valid;
    if (m_owner < 0) begin
      m_low = 0;
      if (req0_valid && req1_valid) m_owner = (m_last == 1) ? 0 : 1;
      else if (req0_valid)          m_owner = 0;
      else if (req1_valid)          m_owner = 1;
    end else if (acc && ad == EOL_CHAR) begin
      m_last  = m_owner;
      m_owner = -1;
      m_low   = 0;
    end else if (!e_busy && !ov) begin
      m_low++;
      if (m_low == HOLD_TIMEOUT) begin
        m_last  = m_owner;
        m_owner = -1;
        m_low   = 0;
      end
    end else begin
      m_low = 0;
    end
    if (acc) begin
      for (int i = 0; i < NB; i++) m_bits[i] = exp_bit(ad, i);
      m_t = 0;
    end else if (e_busy) begin
      m_t++;
      if (m_t == FRAME_CYC) m_t = -1;
    end
  endtask

  task automatic drive();
    if (rand_mode) begin
      if (q0.size() == 0 && $urandom_range(0, 99) < 6) q0.push_back(rand_byte());
      if (q1.size() == 0 && $urandom_range(0, 99) < 6) q1.push_back(rand_byte());
    end
    req0_valid = (q0.size() != 0);
    req0_data  = req0_valid ? q0[0] : 8'($urandom);
    req1_valid = (q1.size() != 0);
    req1_data  = req1_valid ? q1[0] : 8'($urandom);
  endtask

  // One clock: compare at negedge, update model at posedge, drive 1 unit later.
  task automatic step();
    bit a0, a1;
    @(negedge clk);
    model_outputs();
    check("tx", tx, e_tx);
    check("busy", busy, e_busy);
    check("grant", grant, e_grant);
    check("req0_ready", req0_ready, e_rdy0);
    check("req1_ready", req1_ready, e_rdy1);
    if (req0_ready) acc_log.push_back(int'(req0_data));
    if (req1_ready) acc_log.push_back(256 + int'(req1_data));
    if (busy) begin
      busy_cnt++;
      txs.push_back(tx);
    end
    if (track) begin
      if (!busy && t_idle < 0)        t_idle = cyc;
      if (grant == 2'b10 && t_g < 0)  t_g    = cyc;
    end
    a0 = e_rdy0;
    a1 = e_rdy1;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    cyc++;
    #1;
    if (a0 && !reset && q0.size() != 0) void'(q0.pop_front());
    if (a1 && !reset && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic run_until_quiet(input int budget, input string tag);
    int n;
    bit quiet;
    n     = 0;
    quiet = 1'b0;
    while (!quiet && n < budget) begin
      step();
      n++;
      quiet = (q0.size() == 0) && (q1.size() == 0) && (m_t < 0) && (m_owner < 0);
    end
    check(tag, quiet, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b);
    check(tag, busy_cnt, FRAME_CYC);
    if (txs.size() >= FRAME_CYC)
      for (int i = 0; i < NB; i++) check(tag, txs[i*BAUD_DIV], exp_bit(b, i));
  endtask

  int exp2[3] = '{32'h41, 32'h0A, 256 + 32'h42};
  int exp3[5] = '{256 + 32'h0A, 32'h0A, 256 + 32'h0A, 32'h0A, 256 + 32'h0A};

  initial begin
    int n;
    vectors = 0; miscompares = 0; cyc = 0;
    rand_mode = 1'b0; track = 1'b0;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 2'b00);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    reset = 1'b0;

    // Single byte 0x55: grant one cycle after valid, then ready.
    q0.push_back(8'h55);
    drive();
    busy_cnt = 0; txs.delete();
    step();
    check("t1_grant", grant, 2'b01);
    check("t1_ready", req0_ready, 1);
    run_until_quiet(400, "t1_quiet");
    check_frame("t1_frame", 8'h55);

    // Contention after reset: req0 line (0x41, EOL) completes before req1.
    do_reset();
    acc_log.delete();
    q0.push_back(8'h41); q0.push_back(8'h0A);
    q1.push_back(8'h42);
    drive();
    run_until_quiet(800, "t2_quiet");
    check("t2_count", acc_log.size(), 3);
    for (int i = 0; i < 3 && i < acc_log.size(); i++) check("t2_order", acc_log[i], exp2[i]);

    // Round robin after EOL releases.
    acc_log.delete();
    q1.push_back(8'h0A);
    drive();
    run_until_quiet(400, "t3a_quiet");
    repeat (2) begin
      q0.push_back(8'h0A); q1.push_back(8'h0A);
      drive();
      run_until_quiet(600, "t3b_quiet");
    end
    check("t3_count", acc_log.size(), 5);
    for (int i = 0; i < 5 && i < acc_log.size(); i++) check("t3_order", acc_log[i], exp3[i]);

    // Hold timeout: req0 sends without EOL, req1 waits.
    q0.push_back(8'h31);
    drive();
    n = 0;
    while (m_t < 0 && n < 50) begin step(); n++; end
    q1.push_back(8'h42);
    drive();
    track = 1'b1; t_idle = -1; t_g = -1;
    run_until_quiet(800, "t4_quiet");
    track = 1'b0;
    check("t4_gap", t_g - t_idle, HOLD_TIMEOUT + 1);

    // Asynchronous reset during data bit 3 of 0xA5.
    q0.push_back(8'hA5);
    drive();
    n = 0;
    while (m_t != BAUD_DIV * 4 + 1 && n < 100) begin step(); n++; end
    check("t5_pre_tx", tx, 0);
    #2 reset = 1'b1;
    #1;
    check("t5_tx", tx, 1);
    check("t5_busy", busy, 0);
    check("t5_grant", grant, 2'b00);
    check("t5_ready0", req0_ready, 0);
    model_reset();
    q0.delete();
    drive();
    step();
    reset = 1'b0;
    q0.push_back(8'h3C);
    drive();
    busy_cnt = 0; txs.delete();
    run_until_quiet(400, "t5_quiet");
    check_frame("t5_frame", 8'h3C);

    // Frame length and parity slot for 0x07.
    q0.push_back(8'h07);
    drive();
    busy_cnt = 0; txs.delete();
    run_until_quiet(400, "t6_quiet");
    check_frame("t6_frame", 8'h07);

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    run_until_quiet(3000, "rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
